// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two DM requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view; master is the requester/DM side.
interface dm_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;

  logic          dm_we;
  logic [AW-1:0] dm_adr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;

  logic [1:0]    grant;
  logic          busy;

  modport slave (
    input  m0_req, m0_we, m0_adr, m0_wdata,
    input  m1_req, m1_we, m1_adr, m1_wdata,
    input  dm_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output dm_we, dm_adr, dm_wdata, grant, busy
  );

  modport master (
    output m0_req, m0_we, m0_adr, m0_wdata,
    output m1_req, m1_we, m1_adr, m1_wdata,
    output dm_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  dm_we, dm_adr, dm_wdata, grant, busy
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port sequencer for the single-port data memory: IDLE->ISSUE->WAIT->RESP.
// Define DM_ARB_FIXED_PRIO_EN for fixed M0 priority; default is round-robin.
module dm_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic        clk,
  input  logic        rst,
  dm_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          win;      // owner of the current access: 0 = M0, 1 = M1
  logic          lat_we;
  logic          pick;
  logic          sel_we;
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_wdata;

`ifndef DM_ARB_FIXED_PRIO_EN
  logic last_grant;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pick = bus.m1_req;
`ifdef DM_ARB_FIXED_PRIO_EN
    if (bus.m0_req) pick = 1'b0;
`else
    if (bus.m0_req && bus.m1_req) pick = ~last_grant;
`endif
    sel_we    = pick ? bus.m1_we    : bus.m0_we;
    sel_adr   = pick ? bus.m1_adr   : bus.m0_adr;
    sel_wdata = pick ? bus.m1_wdata : bus.m0_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      win          <= 1'b0;
      lat_we       <= 1'b0;
      bus.grant    <= 2'b00;
      bus.busy     <= 1'b0;
      bus.dm_we    <= 1'b0;
      bus.dm_adr   <= '0;
      bus.dm_wdata <= '0;
      bus.m0_ack   <= 1'b0;
      bus.m1_ack   <= 1'b0;
      bus.m0_rdata <= '0;
      bus.m1_rdata <= '0;
`ifndef DM_ARB_FIXED_PRIO_EN
      last_grant   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            win          <= pick;
            lat_we       <= sel_we;
            // DM inputs are registered here so they are stable through ISSUE
            bus.dm_we    <= sel_we;
            bus.dm_adr   <= sel_adr;
            bus.dm_wdata <= sel_wdata;
            bus.grant    <= pick ? 2'b10 : 2'b01;
            bus.busy     <= 1'b1;
`ifndef DM_ARB_FIXED_PRIO_EN
            last_grant   <= pick;
`endif
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          bus.dm_we <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          if (!lat_we) begin
            if (win) bus.m1_rdata <= bus.dm_rdata;
            else     bus.m0_rdata <= bus.dm_rdata;
          end
          bus.m0_ack <= ~win;
          bus.m1_ack <= win;
          state      <= RESP;
        end
        RESP: begin
          bus.m0_ack <= 1'b0;
          bus.m1_ack <= 1'b0;
          bus.grant  <= 2'b00;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural registered-read DM model.
// Build with DM_ARB_FIXED_PRIO_EN defined to check the fixed-priority variant.
module tb_dm_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dm_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  dm_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // DM model: write on WE, read data registered one cycle after the address
  logic [DW-1:0] mem [0:63];
  initial for (int i = 0; i < 64; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (bus.dm_we) mem[bus.dm_adr[7:2]] <= bus.dm_wdata;
    bus.dm_rdata <= mem[bus.dm_adr[7:2]];
  end

  int total = 0;
  int bad = 0;
  int we_cnt = 0;
  int w0;

  always @(negedge clk) if (bus.dm_we === 1'b1) we_cnt++;

  int         ev_port[$];
  int         ev_cyc[$];
  logic [1:0] ev_grant[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int p, input logic we, input logic [31:0] adr, input logic [31:0] wd);
    if (p == 0) begin
      bus.m0_we = we; bus.m0_adr = adr; bus.m0_wdata = wd; bus.m0_req = 1'b1;
    end else begin
      bus.m1_we = we; bus.m1_adr = adr; bus.m1_wdata = wd; bus.m1_req = 1'b1;
    end
  endtask

  // Runs n cycles starting #1 after a posedge; logs ACKs with their cycle index.
  task automatic window(input int n, input bit drop0, input bit drop1, input int start1);
    logic a0, a1;
    ev_port.delete(); ev_cyc.delete(); ev_grant.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a0 = bus.m0_ack;
      a1 = bus.m1_ack;
      if (a0) begin ev_port.push_back(0); ev_cyc.push_back(i); ev_grant.push_back(bus.grant); end
      if (a1) begin ev_port.push_back(1); ev_cyc.push_back(i); ev_grant.push_back(bus.grant); end
      @(posedge clk);
      #1;
      if (a0 && drop0) bus.m0_req = 1'b0;
      if (a1 && drop1) bus.m1_req = 1'b0;
      if (i == start1) bus.m1_req = 1'b1;
    end
  endtask

  task automatic do_access(input string tag, input int p, input logic we,
                           input logic [31:0] adr, input logic [31:0] wd);
    set_req(p, we, adr, wd);
    window(8, 1'b1, 1'b1, -1);
    check({tag, "_acks"}, ev_port.size(), 1);
    if (ev_port.size() >= 1) begin
      check({tag, "_port"}, ev_port[0], p);
      check({tag, "_lat"}, ev_cyc[0], 3);
      check({tag, "_grant"}, {30'd0, ev_grant[0]}, (p == 0) ? 32'd1 : 32'd2);
    end
  endtask

  initial begin
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_adr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_adr = '0; bus.m1_wdata = '0;

    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_grant", bus.grant, 0);
    check("rst_dm_we", bus.dm_we, 0);
    check("rst_dm_adr", bus.dm_adr, 0);
    check("rst_dm_wdata", bus.dm_wdata, 0);
    check("rst_acks", {bus.m0_ack, bus.m1_ack}, 0);
    check("rst_m0_rdata", bus.m0_rdata, 0);
    check("rst_m1_rdata", bus.m1_rdata, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // M0 write then read back
    w0 = we_cnt;
    do_access("t2_wr", 0, 1'b1, 32'h10, 32'hDEADBEEF);
    check("t2_we_cycles", we_cnt - w0, 1);
    check("t2_mem", mem[4], 32'hDEADBEEF);
    check("t2_wr_keeps_rdata", bus.m0_rdata, 0);
    w0 = we_cnt;
    do_access("t2_rd", 0, 1'b0, 32'h10, 32'h0);
    check("t2_rd_we_cycles", we_cnt - w0, 0);
    check("t2_rdata", bus.m0_rdata, 32'hDEADBEEF);
    check("t2_adr_held", bus.dm_adr, 32'h10);

    // Async reset while an access is in ISSUE
    set_req(0, 1'b0, 32'h10, 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("t1_busy", bus.busy, 0);
    check("t1_grant", bus.grant, 0);
    check("t1_dm_we", bus.dm_we, 0);
    check("t1_dm_adr", bus.dm_adr, 0);
    check("t1_m0_rdata", bus.m0_rdata, 0);
    bus.m0_req = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    window(6, 1'b1, 1'b1, -1);
    check("t1_no_ack", ev_port.size(), 0);

    // Both ports hold read requests
    do_access("t3_w0", 0, 1'b1, 32'h0, 32'h11111111);
    do_access("t3_w1", 1, 1'b1, 32'h4, 32'h22222222);
    set_req(0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 32'h4, 32'h0);
    window(16, 1'b0, 1'b0, -1);
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    check("t3_acks", ev_port.size(), 4);
    for (int k = 0; k < 4 && k < ev_port.size(); k++) begin
`ifdef DM_ARB_FIXED_PRIO_EN
      check($sformatf("t3_port%0d", k), ev_port[k], 0);
`else
      check($sformatf("t3_port%0d", k), ev_port[k], k % 2);
`endif
      check($sformatf("t3_cyc%0d", k), ev_cyc[k], 3 + 4 * k);
    end
    check("t3_m0_rdata", bus.m0_rdata, 32'h11111111);
`ifdef DM_ARB_FIXED_PRIO_EN
    check("t3_m1_rdata", bus.m1_rdata, 32'h0);
`else
    check("t3_m1_rdata", bus.m1_rdata, 32'h22222222);
`endif

    // M1 request arrives while M0 is in ISSUE
    set_req(0, 1'b0, 32'h10, 32'h0);
    bus.m1_we = 1'b0; bus.m1_adr = 32'h4; bus.m1_wdata = 32'h0;
    window(12, 1'b1, 1'b1, 0);
    check("t4_acks", ev_port.size(), 2);
    if (ev_port.size() == 2) begin
      check("t4_first_port", ev_port[0], 0);
      check("t4_first_cyc", ev_cyc[0], 3);
      check("t4_second_port", ev_port[1], 1);
      check("t4_gap", ev_cyc[1] - ev_cyc[0], 4);
    end
    check("t4_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
    check("t4_m1_rdata", bus.m1_rdata, 32'h22222222);

    // Reset during ISSUE of an M1 write: the write must not land
    set_req(1, 1'b1, 32'h20, 32'h1);
    @(posedge clk); #1;
    check("t5_issue_we", bus.dm_we, 1);
    #1;
    rst = 1'b1;
    #1;
    check("t5_we_drop", bus.dm_we, 0);
    check("t5_busy", bus.busy, 0);
    bus.m1_req = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    window(6, 1'b1, 1'b1, -1);
    check("t5_no_ack", ev_port.size(), 0);
    check("t5_mem", mem[8], 32'h0);
    do_access("t5_pre", 0, 1'b0, 32'h10, 32'h0);
    check("t5_pre_rdata", bus.m0_rdata, 32'hDEADBEEF);
    do_access("t5_rd", 0, 1'b0, 32'h20, 32'h0);
    check("t5_rdata", bus.m0_rdata, 32'h0);

    // Cross-port write then read
    do_access("t6_m1rd", 1, 1'b0, 32'h4, 32'h0);
    check("t6_m1_pre", bus.m1_rdata, 32'h22222222);
    do_access("t6_m1wr", 1, 1'b1, 32'h8, 32'hA5A5A5A5);
    check("t6_m1_wr_keeps", bus.m1_rdata, 32'h22222222);
    do_access("t6_m0rd", 0, 1'b0, 32'h8, 32'h0);
    check("t6_m0_rdata", bus.m0_rdata, 32'hA5A5A5A5);
    check("t6_m1_unch", bus.m1_rdata, 32'h22222222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
